// File: rtl/gshare_btb_ongorucu_pkg.sv
// ongorucu_pkg: shared definitions for the gshare branch predictor.
//   - RISC-V opcodes that the predictor recognises (conditional branch, JAL)
//   - 2-bit saturating counter encodings and the value counters are cleared to
//   - FSM state type (TEMIZLE clears the tables, HAZIR serves requests)
// Optional feature macro used by the design files: ONGORUCU_BTB_EN.
package ongorucu_pkg;

  localparam logic [6:0] OPC_DALLAN = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] SAY_GUCLU_ALINMAZ = 2'b00;
  localparam logic [1:0] SAY_ZAYIF_ALINMAZ = 2'b01;
  localparam logic [1:0] SAY_ZAYIF_ALINIR  = 2'b10;
  localparam logic [1:0] SAY_GUCLU_ALINIR  = 2'b11;
  localparam logic [1:0] SAY_SIFIRLA       = SAY_ZAYIF_ALINMAZ;

  typedef enum logic {
    TEMIZLE = 1'b0,
    HAZIR   = 1'b1
  } durum_e;

endpackage

// File: rtl/gshare_btb_ongorucu_if.sv
// gshare_btb_ongorucu_if: fetch, resolve and prediction signals of the predictor.
//   getir_*  : fetch request (PC, instruction word, valid)
//   yurut_*  : resolved branch (PC, instruction, actual target, outcome,
//              prediction carried down the pipe, valid)
//   sonuc_*  : registered prediction (taken, next PC, valid)
//   hazir    : tables initialised, requests accepted
// master = pipeline side driving requests, slave = predictor.
interface gshare_btb_ongorucu_if;

  logic [31:0] getir_ps;
  logic [31:0] getir_buyruk;
  logic        getir_gecerli;
  logic [31:0] yurut_ps;
  logic [31:0] yurut_buyruk;
  logic [31:0] yurut_dallan_ps;
  logic        yurut_dallan;
  logic        yurut_ongoru;
  logic        yurut_gecerli;
  logic        sonuc_dallan;
  logic [31:0] sonuc_dallan_ps;
  logic        sonuc_gecerli;
  logic        hazir;

  modport master (
    output getir_ps, getir_buyruk, getir_gecerli,
    output yurut_ps, yurut_buyruk, yurut_dallan_ps,
    output yurut_dallan, yurut_ongoru, yurut_gecerli,
    input  sonuc_dallan, sonuc_dallan_ps, sonuc_gecerli, hazir
  );

  modport slave (
    input  getir_ps, getir_buyruk, getir_gecerli,
    input  yurut_ps, yurut_buyruk, yurut_dallan_ps,
    input  yurut_dallan, yurut_ongoru, yurut_gecerli,
    output sonuc_dallan, sonuc_dallan_ps, sonuc_gecerli, hazir
  );

endinterface

// File: rtl/gshare_btb_ongorucu_dallan_hedef_tamponu.sv
// dallan_hedef_tamponu: direct-mapped branch target buffer (built only when
// ONGORUCU_BTB_EN is defined).
//   clk_i          : clock
//   temizle_i      : clear valid bit at temizle_idx_i this cycle
//   oku_ps_i       : fetch PC looked up combinationally
//   isabet_o       : entry valid and tag matches
//   hedef_o        : stored target of the indexed entry
//   yaz_i          : write entry for yaz_ps_i with target yaz_hedef_i
// Reads see the contents before a same-cycle write.
module dallan_hedef_tamponu #(
  parameter int BTB_IDX_W = 4
) (
  input  logic                 clk_i,
  input  logic                 temizle_i,
  input  logic [BTB_IDX_W-1:0] temizle_idx_i,
  input  logic [31:0]          oku_ps_i,
  output logic                 isabet_o,
  output logic [31:0]          hedef_o,
  input  logic                 yaz_i,
  input  logic [31:0]          yaz_ps_i,
  input  logic [31:0]          yaz_hedef_i
);

  localparam int ETIKET_W = 30 - BTB_IDX_W;
  localparam int BTB_N    = 1 << BTB_IDX_W;

  logic                gecerli_q [BTB_N];
  logic [ETIKET_W-1:0] etiket_q  [BTB_N];
  logic [31:0]         hedef_q   [BTB_N];

  logic [BTB_IDX_W-1:0] oku_idx;
  logic [BTB_IDX_W-1:0] yaz_idx;
  logic                 unused_bits;

  assign oku_idx     = oku_ps_i[BTB_IDX_W+1:2];
  assign yaz_idx     = yaz_ps_i[BTB_IDX_W+1:2];
  assign isabet_o    = gecerli_q[oku_idx] && (etiket_q[oku_idx] == oku_ps_i[31:BTB_IDX_W+2]);
  assign hedef_o     = hedef_q[oku_idx];
  assign unused_bits = ^{oku_ps_i[1:0], yaz_ps_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (temizle_i) begin
      gecerli_q[temizle_idx_i] <= 1'b0;
    end else if (yaz_i) begin
      gecerli_q[yaz_idx] <= 1'b1;
      etiket_q[yaz_idx]  <= yaz_ps_i[31:BTB_IDX_W+2];
      hedef_q[yaz_idx]   <= yaz_hedef_i;
    end
  end

endmodule

// File: rtl/gshare_btb_ongorucu.sv
// gshare_btb_ongorucu: gshare conditional-branch predictor with registered
// prediction output.
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset; restarts table clearing
//   bus  : gshare_btb_ongorucu_if.slave (fetch, resolve, prediction, hazir)
// Option ONGORUCU_BTB_EN: targets come from a direct-mapped BTB
// (dallan_hedef_tamponu); otherwise they are decoded from the B/J immediate.
// GHR_W must not exceed PHT_IDX_W; with the BTB, BTB_IDX_W must not exceed
// PHT_IDX_W so the clearing sweep covers every BTB entry.
module gshare_btb_ongorucu
  import ongorucu_pkg::*;
#(
  parameter int GHR_W     = 8,
  parameter int PHT_IDX_W = 8,
  parameter int BTB_IDX_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  gshare_btb_ongorucu_if.slave bus
);

  localparam int PHT_N = 1 << PHT_IDX_W;

  function automatic logic [1:0] doyurarak_say(input logic [1:0] s, input logic alindi);
    if (alindi) return (s == SAY_GUCLU_ALINIR) ? s : s + 2'd1;
    else        return (s == SAY_GUCLU_ALINMAZ) ? s : s - 2'd1;
  endfunction

  function automatic logic [GHR_W-1:0] ghr_kaydir(input logic [GHR_W-1:0] g, input logic b);
    logic [GHR_W:0] t;
    t = {g, b};
    return t[GHR_W-1:0];
  endfunction

  durum_e               durum_q, durum_d;
  logic [PHT_IDX_W-1:0] sayac_q, sayac_d;
  logic [GHR_W-1:0]     spek_ghr_q, spek_ghr_d;
  logic [GHR_W-1:0]     kesin_ghr_q, kesin_ghr_d;
  logic [1:0]           pht_q [PHT_N];

  logic                 hazir;
  logic                 getir_en, getir_kosullu, getir_jal;
  logic                 yurut_en, yurut_jal, yanlis_ongoru, btb_yaz;
  logic [PHT_IDX_W-1:0] getir_idx, yurut_idx;
  logic [31:0]          ardisik_ps, hedef_ps, sonraki_ps;
  logic                 hedef_bilinen, tahmin;

  logic                 vld_p1;
  logic                 dallan_p1;
  logic [31:0]          ps_p1;

  assign hazir         = (durum_q == HAZIR);
  assign getir_en      = bus.getir_gecerli & hazir;
  assign getir_kosullu = (bus.getir_buyruk[6:0] == OPC_DALLAN);
  assign getir_jal     = (bus.getir_buyruk[6:0] == OPC_JAL);
  assign yurut_jal     = (bus.yurut_buyruk[6:0] == OPC_JAL);
  assign yurut_en      = bus.yurut_gecerli & hazir & (bus.yurut_buyruk[6:0] == OPC_DALLAN);
  assign yanlis_ongoru = yurut_en & (bus.yurut_dallan != bus.yurut_ongoru);
  assign btb_yaz       = bus.yurut_gecerli & hazir & bus.yurut_dallan
                       & ((bus.yurut_buyruk[6:0] == OPC_DALLAN) | yurut_jal);
  assign getir_idx     = bus.getir_ps[PHT_IDX_W+1:2] ^ PHT_IDX_W'(spek_ghr_q);
  assign yurut_idx     = bus.yurut_ps[PHT_IDX_W+1:2] ^ PHT_IDX_W'(kesin_ghr_q);
  assign ardisik_ps    = bus.getir_ps + 32'd4;

`ifdef ONGORUCU_BTB_EN
  logic unused_bits;
  assign unused_bits = ^{bus.getir_buyruk[31:7], bus.yurut_buyruk[31:7]};

  dallan_hedef_tamponu #(
    .BTB_IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk_i         (clk),
    .temizle_i     (durum_q == TEMIZLE),
    .temizle_idx_i (sayac_q[BTB_IDX_W-1:0]),
    .oku_ps_i      (bus.getir_ps),
    .isabet_o      (hedef_bilinen),
    .hedef_o       (hedef_ps),
    .yaz_i         (btb_yaz),
    .yaz_ps_i      (bus.yurut_ps),
    .yaz_hedef_i   (bus.yurut_dallan_ps)
  );
`else
  logic signed [31:0]   imm_b, imm_j;
  logic                 unused_bits;
  logic [BTB_IDX_W-1:0] unused_btb_w;

  assign imm_b = {{20{bus.getir_buyruk[31]}}, bus.getir_buyruk[7], bus.getir_buyruk[30:25],
                  bus.getir_buyruk[11:8], 1'b0};
  assign imm_j = {{12{bus.getir_buyruk[31]}}, bus.getir_buyruk[19:12], bus.getir_buyruk[20],
                  bus.getir_buyruk[30:21], 1'b0};
  assign hedef_ps      = bus.getir_ps + (getir_jal ? $unsigned(imm_j) : $unsigned(imm_b));
  assign hedef_bilinen = 1'b1;
  assign unused_bits   = ^{bus.yurut_ps, bus.yurut_buyruk[31:7], bus.yurut_dallan_ps, btb_yaz};
  assign unused_btb_w  = '0;
`endif

  always_comb begin
    tahmin = 1'b0;
    if (getir_kosullu)  tahmin = pht_q[getir_idx][1] & hedef_bilinen;
    else if (getir_jal) tahmin = hedef_bilinen;
  end

  assign sonraki_ps = tahmin ? hedef_ps : ardisik_ps;

  always_comb begin
    durum_d     = durum_q;
    sayac_d     = sayac_q;
    spek_ghr_d  = spek_ghr_q;
    kesin_ghr_d = kesin_ghr_q;
    case (durum_q)
      TEMIZLE: begin
        sayac_d = sayac_q + 1'b1;
        if (sayac_q == '1) durum_d = HAZIR;
      end
      HAZIR: begin
        if (getir_en & getir_kosullu) spek_ghr_d  = ghr_kaydir(spek_ghr_q, tahmin);
        if (yurut_en)                 kesin_ghr_d = ghr_kaydir(kesin_ghr_q, bus.yurut_dallan);
        // A mispredict rebuilds the speculative history from the committed one,
        // discarding whatever the fetch side shifted in this cycle.
        if (yanlis_ongoru)            spek_ghr_d  = ghr_kaydir(kesin_ghr_q, bus.yurut_dallan);
      end
      default: durum_d = TEMIZLE;
    endcase
  end

  // ---- stage p0 -> p1: registered prediction and predictor state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q     <= TEMIZLE;
      sayac_q     <= '0;
      spek_ghr_q  <= '0;
      kesin_ghr_q <= '0;
      vld_p1      <= 1'b0;
      dallan_p1   <= 1'b0;
      ps_p1       <= '0;
    end else begin
      durum_q     <= durum_d;
      sayac_q     <= sayac_d;
      spek_ghr_q  <= spek_ghr_d;
      kesin_ghr_q <= kesin_ghr_d;
      vld_p1      <= getir_en;
      if (getir_en) begin
        dallan_p1 <= tahmin;
        ps_p1     <= sonraki_ps;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (durum_q == TEMIZLE) begin
      pht_q[sayac_q] <= SAY_SIFIRLA;
    end else if (yurut_en) begin
      pht_q[yurut_idx] <= doyurarak_say(pht_q[yurut_idx], bus.yurut_dallan);
    end
  end

  assign bus.sonuc_gecerli   = vld_p1;
  assign bus.sonuc_dallan    = dallan_p1;
  assign bus.sonuc_dallan_ps = ps_p1;
  assign bus.hazir           = hazir;

endmodule

// File: tb/tb_gshare_btb_ongorucu.sv
`timescale 1ns/1ps
module tb_gshare_btb_ongorucu;
  import ongorucu_pkg::*;

  localparam int GHR_W     = 8;
  localparam int PHT_IDX_W = 8;
  localparam int BTB_IDX_W = 4;
  localparam int PHT_N     = 1 << PHT_IDX_W;
  localparam int unsigned GHR_MASK = (1 << GHR_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gshare_btb_ongorucu_if bus();

  gshare_btb_ongorucu #(
    .GHR_W     (GHR_W),
    .PHT_IDX_W (PHT_IDX_W),
    .BTB_IDX_W (BTB_IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the predictor must hold after the last edge.
  int unsigned m_cnt [PHT_N];
  int unsigned m_spek, m_kesin;
  bit          m_ready, m_known;
  int          m_clear_left;
`ifdef ONGORUCU_BTB_EN
  localparam int BTB_N = 1 << BTB_IDX_W;
  bit          m_bv   [BTB_N];
  int unsigned m_btag [BTB_N];
  int unsigned m_btgt [BTB_N];
`else
  function automatic int unsigned imm_b(input int unsigned w);
    int unsigned v;
    v = (((w >> 8) & 15) << 1) | (((w >> 25) & 63) << 5) | (((w >> 7) & 1) << 11);
    if (((w >> 31) & 1) != 0) v = v - 4096;
    return v;
  endfunction

  function automatic int unsigned imm_j(input int unsigned w);
    int unsigned v;
    v = (((w >> 21) & 1023) << 1) | (((w >> 20) & 1) << 11) | (((w >> 12) & 255) << 12);
    if (((w >> 31) & 1) != 0) v = v - (1 << 20);
    return v;
  endfunction
`endif

  bit          exp_hazir, exp_vld, exp_dallan;
  int unsigned exp_ps;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int unsigned op, pc, tgt, idx, ridx, rop, new_spek;
    bit known, pred;
    if (rst) begin
      m_known = 1; m_ready = 0; m_clear_left = PHT_N;
      m_spek = 0; m_kesin = 0;
      exp_vld = 0; exp_dallan = 0; exp_ps = 0;
    end else if (!m_ready) begin
      exp_vld = 0;
      m_clear_left--;
      if (m_clear_left == 0) begin
        m_ready = 1;
        foreach (m_cnt[i]) m_cnt[i] = 1;
`ifdef ONGORUCU_BTB_EN
        foreach (m_bv[i]) m_bv[i] = 0;
`endif
      end
    end else begin
      new_spek = m_spek;
      exp_vld  = bus.getir_gecerli;
      if (bus.getir_gecerli) begin
        pc = bus.getir_ps;
        op = bus.getir_buyruk & 127;
`ifdef ONGORUCU_BTB_EN
        idx   = (pc >> 2) % BTB_N;
        known = m_bv[idx] && (m_btag[idx] == (pc >> (BTB_IDX_W + 2)));
        tgt   = m_btgt[idx];
`else
        known = 1;
        tgt   = pc + ((op == OPC_JAL) ? imm_j(bus.getir_buyruk) : imm_b(bus.getir_buyruk));
`endif
        pred = 0;
        if (op == OPC_DALLAN) begin
          idx      = ((pc >> 2) ^ m_spek) % PHT_N;
          pred     = (m_cnt[idx] >= 2) && known;
          new_spek = ((m_spek << 1) | pred) & GHR_MASK;
        end else if (op == OPC_JAL) begin
          pred = known;
        end
        exp_dallan = pred;
        exp_ps     = pred ? tgt : pc + 4;
      end
      rop = bus.yurut_buyruk & 127;
      if (bus.yurut_gecerli && rop == OPC_DALLAN) begin
        ridx = ((bus.yurut_ps >> 2) ^ m_kesin) % PHT_N;
        if (bus.yurut_dallan && m_cnt[ridx] < 3) m_cnt[ridx]++;
        else if (!bus.yurut_dallan && m_cnt[ridx] > 0) m_cnt[ridx]--;
        m_kesin = ((m_kesin << 1) | bus.yurut_dallan) & GHR_MASK;
        if (bus.yurut_dallan != bus.yurut_ongoru) new_spek = m_kesin;
      end
`ifdef ONGORUCU_BTB_EN
      if (bus.yurut_gecerli && bus.yurut_dallan && (rop == OPC_DALLAN || rop == OPC_JAL)) begin
        idx = (bus.yurut_ps >> 2) % BTB_N;
        m_bv[idx]   = 1;
        m_btag[idx] = bus.yurut_ps >> (BTB_IDX_W + 2);
        m_btgt[idx] = bus.yurut_dallan_ps;
      end
`endif
      m_spek = new_spek;
    end
    exp_hazir = m_ready;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      chk("hazir", 32'(bus.hazir), 32'(exp_hazir));
      chk("sonuc_gecerli", 32'(bus.sonuc_gecerli), 32'(exp_vld));
      if (exp_vld) begin
        chk("sonuc_dallan", 32'(bus.sonuc_dallan), 32'(exp_dallan));
        chk("sonuc_dallan_ps", bus.sonuc_dallan_ps, exp_ps);
      end
    end
  end

  task automatic idle();
    bus.getir_gecerli = 0; bus.getir_ps = '0; bus.getir_buyruk = '0;
    bus.yurut_gecerli = 0; bus.yurut_ps = '0; bus.yurut_buyruk = '0;
    bus.yurut_dallan_ps = '0; bus.yurut_dallan = 0; bus.yurut_ongoru = 0;
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] p;
    if ($urandom_range(0, 31) == 0) p = 32'hFFFF_FFFC;
    else p = (32'($urandom_range(0, 1)) << 12) | (32'h100 + (32'($urandom_range(0, 15)) << 2));
    return p;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0, 1:    w[6:0] = OPC_DALLAN;
      2:       w[6:0] = OPC_JAL;
      default: w[6:0] = 7'h13;
    endcase
    return w;
  endfunction

  task automatic rnd_inputs();
    bus.getir_gecerli   = ($urandom_range(0, 3) != 0);
    bus.getir_ps        = rnd_pc();
    bus.getir_buyruk    = rnd_instr();
    bus.yurut_gecerli   = $urandom_range(0, 1);
    bus.yurut_ps        = rnd_pc();
    bus.yurut_buyruk    = rnd_instr();
    bus.yurut_dallan_ps = $urandom & 32'hFFFF_FFFC;
    bus.yurut_dallan    = $urandom_range(0, 1);
    bus.yurut_ongoru    = $urandom_range(0, 1);
  endtask

  // Counts edges from reset release until hazir; the default tables take 256.
  task automatic wait_ready(input string name, input bit noisy);
    int n;
    n = 0;
    while (!bus.hazir && n < 400) begin
      if (noisy) rnd_inputs(); else idle();
      cyc();
      n++;
    end
    idle();
    chk(name, 32'(n), 32'd256);
  endtask

  task automatic do_reset();
    rst = 1; cyc();
    chk("rst_hazir", 32'(bus.hazir), 32'd0);
    chk("rst_gecerli", 32'(bus.sonuc_gecerli), 32'd0);
    chk("rst_dallan", 32'(bus.sonuc_dallan), 32'd0);
    chk("rst_ps", bus.sonuc_dallan_ps, 32'd0);
    rst = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
    bus.getir_gecerli = 1; bus.getir_ps = pc; bus.getir_buyruk = ins;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    do_reset();
    wait_ready("clear_len_first", 1);

    // reset in the middle of clearing restarts the sweep
    do_reset();
    repeat (100) cyc();
    chk("mid_clear_hazir", 32'(bus.hazir), 32'd0);
    do_reset();
    wait_ready("clear_len_restart", 0);

    // cold beq at 0x100: counter 01, not taken
    fetch(32'h100, 32'h0000_0463); cyc(); idle();
    chk("cold_vld", 32'(bus.sonuc_gecerli), 32'd1);
    chk("cold_dallan", 32'(bus.sonuc_dallan), 32'd0);
    chk("cold_ps", bus.sonuc_dallan_ps, 32'h104);
    cyc();
    chk("idle_vld", 32'(bus.sonuc_gecerli), 32'd0);

    // 12 taken resolves drive the GHR to 0xFF and counter 0xBF to 11
    for (int i = 0; i < 12; i++) begin
      bus.yurut_gecerli = 1; bus.yurut_ps = 32'h100; bus.yurut_buyruk = 32'h0000_0463;
      bus.yurut_dallan = 1; bus.yurut_ongoru = 0; bus.yurut_dallan_ps = 32'h108;
      cyc();
    end
    idle();
    fetch(32'h100, 32'h0000_0463); cyc(); idle();
    chk("trained_dallan", 32'(bus.sonuc_dallan), 32'd1);
    chk("trained_ps", bus.sonuc_dallan_ps, 32'h108);

    fetch(32'h200, 32'h0000_0013); cyc(); idle();
    chk("addi_dallan", 32'(bus.sonuc_dallan), 32'd0);
    chk("addi_ps", bus.sonuc_dallan_ps, 32'h204);
    fetch(32'h100, 32'h0000_0463); cyc(); idle();
    chk("after_addi_dallan", 32'(bus.sonuc_dallan), 32'd1);
    chk("after_addi_ps", bus.sonuc_dallan_ps, 32'h108);

    for (int i = 0; i < 3000; i++) begin
      rnd_inputs();
      cyc();
    end
    idle();

    // same-cycle fetch and resolve of one entry: read-before-write
    do_reset();
    wait_ready("clear_len_hazir_reset", 0);
    fetch(32'h100, 32'h0000_0463);
    bus.yurut_gecerli = 1; bus.yurut_ps = 32'h100; bus.yurut_buyruk = 32'h0000_0463;
    bus.yurut_dallan = 1; bus.yurut_ongoru = 1; bus.yurut_dallan_ps = 32'h108;
    cyc();
    bus.yurut_gecerli = 0;
    chk("rbw_first_dallan", 32'(bus.sonuc_dallan), 32'd0);
    chk("rbw_first_ps", bus.sonuc_dallan_ps, 32'h104);
    cyc(); idle();
    chk("rbw_second_dallan", 32'(bus.sonuc_dallan), 32'd1);
    chk("rbw_second_ps", bus.sonuc_dallan_ps, 32'h108);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gshare_btb_ongorucu.md
GSHARE_BTB_ONGORUCU -- requirements
Module: gshare_btb_ongorucu

Interface
REQ-001 SHALL have parameter GHR_W, default 8, global history length in bits (1..PHT_IDX_W).
REQ-002 SHALL have parameter PHT_IDX_W, default 8, log2 of pattern history table depth.
REQ-003 SHALL have parameter BTB_IDX_W, default 4, log2 of branch target buffer entries.
REQ-004 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports getir_ps, getir_buyruk  input  32 each  fetch PC and instruction word.
REQ-007 SHALL have port getir_gecerli  input  1  fetch request valid.
REQ-008 SHALL have ports yurut_ps, yurut_buyruk, yurut_dallan_ps  input  32 each  resolved PC, instruction, actual target.
REQ-009 SHALL have ports yurut_dallan, yurut_ongoru, yurut_gecerli  input  1 each  actual outcome, prediction carried down the pipe, resolve valid.
REQ-010 SHALL have ports sonuc_dallan  output 1, sonuc_dallan_ps  output 32, sonuc_gecerli  output 1: prediction, next PC, prediction valid.
REQ-011 SHALL have port hazir  output  1  tables initialised, requests accepted.

Function
REQ-012 Conditional branch = opcode [6:0] 1100011; JAL = 1101111; all other opcodes non-branch.
REQ-013 PHT: 2^PHT_IDX_W 2-bit saturating counters; taken increments to max 11, not-taken decrements to min 00; predict taken iff MSB=1.
REQ-014 Fetch index = ps[PHT_IDX_W+1:2] XOR zero-extended spek_ghr; resolve index = yurut_ps[PHT_IDX_W+1:2] XOR zero-extended kesin_ghr.
REQ-015 Prediction registered: outputs valid exactly 1 cycle after getir_gecerli=1 with hazir=1; sonuc_gecerli=0 otherwise.
REQ-016 Non-branch: sonuc_dallan=0, sonuc_dallan_ps=getir_ps+4 (mod 2^32), no GHR change.
REQ-017 Conditional branch: sonuc_dallan=PHT MSB AND target known; sonuc_dallan_ps=target if sonuc_dallan else getir_ps+4; spek_ghr shifts in sonuc_dallan.
REQ-018 JAL: sonuc_dallan=1 iff target known; PHT and GHRs untouched.
REQ-019 Resolve (yurut_gecerli=1, hazir=1, conditional branch): update PHT at resolve index with yurut_dallan; kesin_ghr shifts in yurut_dallan.
REQ-020 Mispredict = conditional branch resolve with yurut_dallan != yurut_ongoru: spek_ghr <= {kesin_ghr[GHR_W-2:0], yurut_dallan}; overrides same-cycle fetch shift.
REQ-021 Same-cycle fetch and resolve to one PHT entry: prediction uses pre-update value (read-before-write).
REQ-022 FSM states TEMIZLE, HAZIR; TEMIZLE writes counter 01 and BTB valid=0 at index sayac each cycle; after entry 2^PHT_IDX_W-1 -> HAZIR; hazir=1 only in HAZIR.
REQ-023 In TEMIZLE fetch and resolve inputs ignored, sonuc_gecerli=0.

Reset
REQ-024 rst=1 SHALL force TEMIZLE, sayac=0, spek_ghr=kesin_ghr=0, sonuc_dallan=0, sonuc_dallan_ps=0, sonuc_gecerli=0, hazir=0.
REQ-025 rst during TEMIZLE or HAZIR SHALL restart clearing from index 0.

Configuration
REQ-026 With ONGORUCU_BTB_EN defined: direct-mapped BTB, index ps[BTB_IDX_W+1:2], tag ps[31:BTB_IDX_W+2], valid bit; target known iff valid and tag match; resolve with yurut_dallan=1 on branch/JAL writes yurut_dallan_ps.
REQ-027 Without ONGORUCU_BTB_EN: no BTB storage; target = getir_ps + sign-extended B-type (branch) or J-type (JAL) immediate, always known.

Structure
REQ-028 Package ongorucu_pkg SHALL hold opcode constants, counter encodings (00..11, reset 01), FSM state enum.
REQ-029 BTB SHALL be sub-module dallan_hedef_tamponu, instantiated only under ONGORUCU_BTB_EN.

Verification
REQ-030 rst high 1 cycle -> hazir=0, sonuc_gecerli=0 for 256 cycles, hazir=1 on cycle 257 (defaults).
REQ-031 Reset asserted at clearing cycle 100 -> hazir rises 256 cycles after rst deassertion.
REQ-032 Cold fetch 0x100, 0x00000463 (beq +8) -> next cycle sonuc_gecerli=1, sonuc_dallan=0, ps 0x104 (BTB_EN); sonuc_dallan=0, ps 0x104 (no BTB, counter 01).
REQ-033 12 resolves yurut_ps=0x100, 0x00000463, dallan=1, ongoru=0, dallan_ps=0x108, then fetch 0x100 -> sonuc_dallan=1, ps 0x108.
REQ-034 Fetch 0x200, 0x00000013 (addi) -> sonuc_dallan=0, ps 0x204, GHR unchanged.
REQ-035 Fetch and resolve same PHT entry same cycle, counter 01, dallan=1 -> prediction 0; repeat fetch next cycle -> 1.
